mem_stage_access: RTL and testbench
===================================

# mem_stage_access

Memory-stage access controller for the 20-bit pipelined processor. It consumes the EX/MEM pipeline register outputs and drives the data-memory req/ack handshake for loads and stores. While an access is outstanding it stalls the upstream pipeline. Its registered outputs form the MEM/WB register, including a one-cycle branch-taken pulse.

## Interface
Parameters:
- OP_LW, 4'h1, opcode (instruction[19:16]) of a load
- OP_SW, 4'h2, opcode of a store
- OP_BEQ, 4'h3, opcode of branch-if-equal
- TIMEOUT, 8'd16, max wait cycles for dmem_ack (used only with MEM_STAGE_TIMEOUT_EN)

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- instruction  in  20  from EX/MEM; opcode = [19:16]; 20'b0 is NOP
- aluZERO  in  1  ALU zero flag from EX/MEM
- aluRESULT  in  20  ALU result; effective address for LW/SW
- storeDATA  in  20  store data for SW
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write (SW), 0 = read (LW)
- dmem_addr  out  20  registered address
- dmem_wdata  out  20  registered store data
- dmem_rdata  in  20  read data, valid when dmem_ack=1
- dmem_ack  in  1  one-cycle completion strobe
- stall  out  1  combinational; 1 = upstream registers hold
- branchTAKEN  out  1  registered one-cycle pulse
- validOUT  out  1  MEM/WB slot holds a real instruction
- memDATAout  out  20  load data to MEM/WB
- aluRESULTout  out  20  ALU result/address to MEM/WB
- instructionPropagation  out  20  instruction to MEM/WB
- memERROR  out  1  timeout abort pulse

## Operation
- State machine: IDLE, WAIT.
- IDLE, non-memory opcode, each posedge:
  - aluRESULTout <= aluRESULT; instructionPropagation <= instruction; memDATAout <= 0
  - validOUT <= (instruction != 0)
  - branchTAKEN <= (opcode==OP_BEQ) && aluZERO
- IDLE, opcode LW/SW:
  - capture dmem_addr <= aluRESULT, dmem_wdata <= storeDATA (SW) else 0, dmem_we <= (opcode==OP_SW)
  - save the instruction internally; dmem_req <= 1; go to WAIT
  - MEM/WB gets a bubble (validOUT <= 0, instructionPropagation <= 0); branchTAKEN <= 0
- WAIT: inputs ignored; each cycle without ack emits a bubble.
- WAIT with dmem_ack=1, at the posedge:
  - dmem_req <= 0
  - memDATAout <= dmem_rdata for LW, 0 for SW
  - aluRESULTout <= dmem_addr; instructionPropagation <= saved instruction; validOUT <= 1
  - go to IDLE
- stall = (state==IDLE && opcode is LW/SW) || (state==WAIT && !dmem_ack && !abort).
- dmem_ack in IDLE is ignored.
- Reset, including mid-access: state IDLE; all outputs 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, branchTAKEN, validOUT, memDATAout, aluRESULTout, instructionPropagation, memERROR); timeout counter 0.

## Timing
- Non-memory instruction: 1-cycle latency into MEM/WB; no stall.
- Memory instruction, instruction visible in cycle k:
  - stall=1 in cycle k; dmem_req=1 from cycle k+1.
  - ack in cycle k+1 gives the result at the end of k+1; stall=0 in k+1 (1 stall cycle minimum).
  - ack in cycle k+n gives n stall cycles.
- The upstream register advances on the ack edge. The next instruction reaches the inputs in the following cycle, which is IDLE, so no instruction is lost or duplicated.
- Back-to-back LW/SW: the second one enters WAIT one cycle after the first completes.
- dmem_addr/we/wdata stay stable for the whole time dmem_req=1.

## Configuration
- MEM_STAGE_TIMEOUT_EN defined:
  - 8-bit counter cleared on entering WAIT, incremented on each WAIT cycle without ack.
  - If count==TIMEOUT and no ack (abort): dmem_req <= 0, memERROR <= 1 for one cycle, bubble emitted, instruction dropped, go to IDLE; stall=0 in the abort cycle.
  - Ack in the same cycle as abort: ack wins, memERROR stays 0.
- Not defined: WAIT persists until ack, counter not built, memERROR tied to 0.

## Test plan
- Reset, then instruction=20'h5_0000 (opcode 5), aluRESULT=20'h00ABC -> next cycle aluRESULTout=20'h00ABC, validOUT=1, stall never 1.
- BEQ (20'h3_0000) with aluZERO=1 -> branchTAKEN=1 for exactly one cycle; with aluZERO=0 -> stays 0.
- LW addr 20'h00010, ack after 3 cycles with rdata=20'hBEEF1 -> stall high 3 cycles, dmem_we=0, then memDATAout=20'hBEEF1, validOUT=1, dmem_req=0.
- SW addr 20'h00020, storeDATA=20'h12345, ack on the first req cycle -> dmem_we=1, dmem_wdata=20'h12345, 1 stall cycle, memDATAout=0.
- Reset asserted in WAIT, then ack arrives -> dmem_req=0 next cycle, all outputs 0, ack ignored, state IDLE.
- With MEM_STAGE_TIMEOUT_EN and TIMEOUT=4, LW with no ack -> memERROR pulses once, validOUT=0, stall drops in the abort cycle. Repeat with ack in the abort cycle -> normal completion, memERROR=0.

Source files
------------

// File: rtl/mem_stage_access.sv
// Memory-stage access controller: drives the data-memory req/ack handshake for LW/SW,
// stalls upstream while an access is outstanding, and registers the MEM/WB slot.
// Optional: define MEM_STAGE_TIMEOUT_EN to abort accesses whose ack never arrives.
module mem_stage_access #(
    parameter logic [3:0] OP_LW   = 4'h1,
    parameter logic [3:0] OP_SW   = 4'h2,
    parameter logic [3:0] OP_BEQ  = 4'h3,
    parameter logic [7:0] TIMEOUT = 8'd16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] instruction,
    input  logic        aluZERO,
    input  logic [19:0] aluRESULT,
    input  logic [19:0] storeDATA,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [19:0] dmem_addr,
    output logic [19:0] dmem_wdata,
    input  logic [19:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        branchTAKEN,
    output logic        validOUT,
    output logic [19:0] memDATAout,
    output logic [19:0] aluRESULTout,
    output logic [19:0] instructionPropagation,
    output logic        memERROR
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]  state;
    logic [19:0] saved_instr;
    logic [3:0]  opcode;
    logic        is_mem;
    logic        abort;

    assign opcode = instruction[19:16];
    assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);

`ifdef MEM_STAGE_TIMEOUT_EN
    logic [7:0] wait_count;

    assign abort = (state == WAIT) && !dmem_ack && (wait_count == TIMEOUT);

    // Counts WAIT cycles without ack; restarts each time a new access is launched.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_count <= 8'd0;
        end else if ((state == IDLE) && is_mem) begin
            wait_count <= 8'd0;
        end else if ((state == WAIT) && !dmem_ack && !abort) begin
            wait_count <= wait_count + 8'd1;
        end else begin
            wait_count <= wait_count;
        end
    end

    // One-cycle error pulse on the abort edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            memERROR <= 1'b0;
        end else begin
            memERROR <= abort;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign abort          = 1'b0;
    assign memERROR       = 1'b0;
`endif

    // Held low during reset so a memory opcode on the inputs cannot freeze upstream.
    assign stall = !reset && (((state == IDLE) && is_mem) ||
                              ((state == WAIT) && !dmem_ack && !abort));

    // Access FSM plus the MEM/WB output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                  <= IDLE;
            saved_instr            <= 20'd0;
            dmem_req               <= 1'b0;
            dmem_we                <= 1'b0;
            dmem_addr              <= 20'd0;
            dmem_wdata             <= 20'd0;
            branchTAKEN            <= 1'b0;
            validOUT               <= 1'b0;
            memDATAout             <= 20'd0;
            aluRESULTout           <= 20'd0;
            instructionPropagation <= 20'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        dmem_addr              <= aluRESULT;
                        dmem_wdata             <= (opcode == OP_SW) ? storeDATA : 20'd0;
                        dmem_we                <= (opcode == OP_SW);
                        saved_instr            <= instruction;
                        dmem_req               <= 1'b1;
                        validOUT               <= 1'b0;
                        instructionPropagation <= 20'd0;
                        branchTAKEN            <= 1'b0;
                        state                  <= WAIT;
                    end else begin
                        aluRESULTout           <= aluRESULT;
                        instructionPropagation <= instruction;
                        memDATAout             <= 20'd0;
                        validOUT               <= (instruction != 20'd0);
                        branchTAKEN            <= (opcode == OP_BEQ) && aluZERO;
                    end
                end
                WAIT: begin
                    branchTAKEN <= 1'b0;
                    if (dmem_ack) begin
                        dmem_req               <= 1'b0;
                        memDATAout             <= dmem_we ? 20'd0 : dmem_rdata;
                        aluRESULTout           <= dmem_addr;
                        instructionPropagation <= saved_instr;
                        validOUT               <= 1'b1;
                        state                  <= IDLE;
                    end else if (abort) begin
                        // Timed-out access is dropped; only a bubble reaches MEM/WB.
                        dmem_req               <= 1'b0;
                        validOUT               <= 1'b0;
                        instructionPropagation <= 20'd0;
                        state                  <= IDLE;
                    end else begin
                        validOUT               <= 1'b0;
                        instructionPropagation <= 20'd0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: directed vector table, random LW/SW/ALU mix
// against a transaction-level expectation, and reset / timeout corner sequences.
module tb_mem_stage_access;

    logic        clock = 1'b0;
    logic        reset;
    logic [19:0] instruction;
    logic        aluZERO;
    logic [19:0] aluRESULT;
    logic [19:0] storeDATA;
    logic        dmem_req;
    logic        dmem_we;
    logic [19:0] dmem_addr;
    logic [19:0] dmem_wdata;
    logic [19:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic        branchTAKEN;
    logic        validOUT;
    logic [19:0] memDATAout;
    logic [19:0] aluRESULTout;
    logic [19:0] instructionPropagation;
    logic        memERROR;

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_stage_access #(.TIMEOUT(8'd4)) dut (
        .clock(clock), .reset(reset), .instruction(instruction), .aluZERO(aluZERO),
        .aluRESULT(aluRESULT), .storeDATA(storeDATA), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
        .branchTAKEN(branchTAKEN), .validOUT(validOUT), .memDATAout(memDATAout),
        .aluRESULTout(aluRESULTout), .instructionPropagation(instructionPropagation),
        .memERROR(memERROR)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [19:0] instr;
        logic        zero;
        logic [19:0] alu;
        logic        exp_valid;
        logic        exp_branch;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
        chk({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
        chk({tag, "_addr"}, {12'd0, dmem_addr}, 32'd0);
        chk({tag, "_wdata"}, {12'd0, dmem_wdata}, 32'd0);
        chk({tag, "_branch"}, {31'd0, branchTAKEN}, 32'd0);
        chk({tag, "_valid"}, {31'd0, validOUT}, 32'd0);
        chk({tag, "_memdata"}, {12'd0, memDATAout}, 32'd0);
        chk({tag, "_alures"}, {12'd0, aluRESULTout}, 32'd0);
        chk({tag, "_instr"}, {12'd0, instructionPropagation}, 32'd0);
        chk({tag, "_err"}, {31'd0, memERROR}, 32'd0);
    endtask

    // Non-memory instruction: no stall, results one cycle later.
    task automatic alu_op(input logic [19:0] ins, input logic zero, input logic [19:0] alu,
                          input logic exp_valid, input logic exp_branch);
        instruction = ins; aluZERO = zero; aluRESULT = alu; storeDATA = 20'($urandom);
        #1 chk("alu_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        chk("alu_result", {12'd0, aluRESULTout}, {12'd0, alu});
        chk("alu_instr", {12'd0, instructionPropagation}, {12'd0, ins});
        chk("alu_valid", {31'd0, validOUT}, {31'd0, exp_valid});
        chk("alu_branch", {31'd0, branchTAKEN}, {31'd0, exp_branch});
        chk("alu_memdata", {12'd0, memDATAout}, 32'd0);
    endtask

    // LW/SW with the ack arriving n cycles after the instruction is presented (n >= 1).
    task automatic mem_op(input logic sw, input logic [19:0] addr, input logic [19:0] sdata,
                          input logic [19:0] rd, input int n);
        logic [19:0] ins;
        ins = {(sw ? 4'h2 : 4'h1), 16'($urandom)};
        instruction = ins; aluRESULT = addr; storeDATA = sdata; aluZERO = 1'($urandom);
        dmem_ack = 1'b0;
        #1 chk("mem_stall_issue", {31'd0, stall}, 32'd1);
        @(negedge clock);
        chk("mem_req", {31'd0, dmem_req}, 32'd1);
        chk("mem_we", {31'd0, dmem_we}, {31'd0, sw});
        chk("mem_addr", {12'd0, dmem_addr}, {12'd0, addr});
        chk("mem_wdata", {12'd0, dmem_wdata}, sw ? {12'd0, sdata} : 32'd0);
        chk("mem_bubble_valid", {31'd0, validOUT}, 32'd0);
        chk("mem_bubble_instr", {12'd0, instructionPropagation}, 32'd0);
        chk("mem_branch", {31'd0, branchTAKEN}, 32'd0);
        for (int i = 1; i < n; i++) begin
            instruction = 20'($urandom); aluRESULT = 20'($urandom); storeDATA = 20'($urandom);
            #1 chk("mem_stall_wait", {31'd0, stall}, 32'd1);
            @(negedge clock);
            chk("wait_bubble", {31'd0, validOUT}, 32'd0);
            chk("wait_req", {31'd0, dmem_req}, 32'd1);
            chk("wait_addr_stable", {12'd0, dmem_addr}, {12'd0, addr});
        end
        dmem_ack = 1'b1; dmem_rdata = rd;
        #1 chk("mem_stall_ack", {31'd0, stall}, 32'd0);
        @(negedge clock);
        dmem_ack = 1'b0; dmem_rdata = 20'($urandom);
        chk("done_req", {31'd0, dmem_req}, 32'd0);
        chk("done_memdata", {12'd0, memDATAout}, sw ? 32'd0 : {12'd0, rd});
        chk("done_alures", {12'd0, aluRESULTout}, {12'd0, addr});
        chk("done_instr", {12'd0, instructionPropagation}, {12'd0, ins});
        chk("done_valid", {31'd0, validOUT}, 32'd1);
        chk("done_branch", {31'd0, branchTAKEN}, 32'd0);
        chk("done_err", {31'd0, memERROR}, 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        reset = 1'b1; instruction = 20'd0; aluZERO = 1'b0; aluRESULT = 20'd0;
        storeDATA = 20'd0; dmem_rdata = 20'd0; dmem_ack = 1'b0;
        vecs[0] = '{20'h50000, 1'b0, 20'h00ABC, 1'b1, 1'b0};
        vecs[1] = '{20'h30000, 1'b1, 20'h00000, 1'b1, 1'b1};
        vecs[2] = '{20'h30000, 1'b0, 20'h00001, 1'b1, 1'b0};
        vecs[3] = '{20'h3ABCD, 1'b1, 20'h00000, 1'b1, 1'b1};
        vecs[4] = '{20'h7FFFF, 1'b1, 20'hFFFFF, 1'b1, 1'b0};
        vecs[5] = '{20'h00000, 1'b1, 20'h12345, 1'b0, 1'b0};

        repeat (2) @(negedge clock);
        check_all_zero("reset");
        chk("reset_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            alu_op(vecs[i].instr, vecs[i].zero, vecs[i].alu, vecs[i].exp_valid, vecs[i].exp_branch);

        mem_op(1'b0, 20'h00010, 20'h00000, 20'hBEEF1, 3);
        mem_op(1'b1, 20'h00020, 20'h12345, 20'h0F0F0, 1);
        mem_op(1'b0, 20'h00030, 20'h00000, 20'h55555, 1);

        // Reset in the middle of an access, ack arriving afterwards must be ignored.
        instruction = 20'h1_0007; aluRESULT = 20'h00040; dmem_ack = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1 chk("rst_wait_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        reset = 1'b0; instruction = 20'd0; dmem_ack = 1'b1; dmem_rdata = 20'hAAAAA;
        check_all_zero("rst_mid");
        #1 chk("rst_idle_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        dmem_ack = 1'b0;
        chk("rst_ack_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_ack_memdata", {12'd0, memDATAout}, 32'd0);
        chk("rst_ack_valid", {31'd0, validOUT}, 32'd0);

`ifdef MEM_STAGE_TIMEOUT_EN
        // No ack: four counted wait cycles, abort in the fifth.
        instruction = 20'h1_0009; aluRESULT = 20'h00050;
        #1 chk("tmo_stall_issue", {31'd0, stall}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1 chk("tmo_stall_wait", {31'd0, stall}, 32'd1);
        end
        @(negedge clock);
        #1 chk("tmo_stall_abort", {31'd0, stall}, 32'd0);
        @(negedge clock);
        instruction = 20'd0;
        chk("tmo_err", {31'd0, memERROR}, 32'd1);
        chk("tmo_valid", {31'd0, validOUT}, 32'd0);
        chk("tmo_req", {31'd0, dmem_req}, 32'd0);
        @(negedge clock);
        chk("tmo_err_pulse", {31'd0, memERROR}, 32'd0);
        // Ack coinciding with the abort cycle completes normally.
        mem_op(1'b0, 20'h00060, 20'h00000, 20'h13579, 5);
`endif

        // Random mix against the transaction-level expectations.
        for (int t = 0; t < 40; t++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                mem_op(1'b0, 20'($urandom), 20'($urandom), 20'($urandom), int'($urandom_range(1, 5)));
            end else if (kind == 1) begin
                mem_op(1'b1, 20'($urandom), 20'($urandom), 20'($urandom), int'($urandom_range(1, 5)));
            end else begin
                logic [3:0]  op;
                logic [19:0] ins;
                logic        z;
                op = 4'($urandom_range(0, 15));
                if (op == 4'h1 || op == 4'h2) op = 4'h3;
                ins = {op, 16'($urandom)};
                if ($urandom_range(0, 7) == 0) ins = 20'd0;
                z = 1'($urandom);
                alu_op(ins, z, 20'($urandom), ins != 20'd0, (ins[19:16] == 4'h3) && z);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
